// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load size/sign codes and the
// canonical NOP used to fill bubbles.
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : wb_pkg

// File: rtl/wb_load_ext.sv
// Load-data extension: sign or zero extends the right-aligned load value
// according to the load size code. Unknown sizes pass the data through.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] ext_data
);

    // Select the extension; size casts of signed slices give sign extension.
    always_comb begin
        ext_data = data;
        case (funct3)
            F3_LB:   ext_data = XLEN'($signed(data[7:0]));
            F3_LH:   ext_data = XLEN'($signed(data[15:0]));
            F3_LW:   ext_data = XLEN'($signed(data[31:0]));
            F3_LBU:  ext_data = XLEN'(data[7:0]);
            F3_LHU:  ext_data = XLEN'(data[15:0]);
            F3_LWU:  ext_data = XLEN'(data[31:0]);
            default: ext_data = data;
        endcase
    end

endmodule : wb_load_ext

// File: rtl/wb_stage_pipe.sv
// MEM-to-WB pipeline register. Selects ALU or extended load data, suppresses
// writes to x0, handles stall/flush and counts retired instructions.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic             mem_memtoreg,
    input  logic [2:0]       mem_funct3,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic [RA_W-1:0]  mem_rs1,
    input  logic [RA_W-1:0]  mem_rs2,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_load_data,
    input  logic [31:0]      mem_instr,
    input  logic             wb_stall,
    input  logic             wb_flush,
    output logic             wb_valid,
    output logic             wb_regwrite,
    output logic [RA_W-1:0]  wb_rd,
    output logic [XLEN-1:0]  wb_write_data,
    output logic [RA_W-1:0]  wb_rs1,
    output logic [RA_W-1:0]  wb_rs2,
    output logic [31:0]      wb_instr,
    output logic [XLEN-1:0]  last_wb_data,
    output logic [CNT_W-1:0] retire_count,
    output logic             retire_pulse
);

    logic [XLEN-1:0] ext_data_s;
    logic [XLEN-1:0] sel_data_s;
    logic            wen_s;

    wb_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .funct3  (mem_funct3),
        .data    (mem_load_data),
        .ext_data(ext_data_s)
    );

    // Result mux and effective write enable (x0 is never written).
    always_comb begin
        if (mem_memtoreg) begin
            sel_data_s = ext_data_s;
        end else begin
            sel_data_s = mem_alu_result;
        end
        wen_s = mem_regwrite & (mem_rd != {RA_W{1'b0}});
    end

    // WB register with flush > stall > normal priority; counter and last data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_rd         <= {RA_W{1'b0}};
            wb_rs1        <= {RA_W{1'b0}};
            wb_rs2        <= {RA_W{1'b0}};
            wb_write_data <= {XLEN{1'b0}};
            wb_instr      <= NOP_INSTR;
            last_wb_data  <= {XLEN{1'b0}};
            retire_count  <= {CNT_W{1'b0}};
            retire_pulse  <= 1'b0;
        end else if (wb_flush) begin
            wb_valid      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_rd         <= {RA_W{1'b0}};
            wb_rs1        <= {RA_W{1'b0}};
            wb_rs2        <= {RA_W{1'b0}};
            wb_write_data <= {XLEN{1'b0}};
            wb_instr      <= NOP_INSTR;
            retire_pulse  <= 1'b0;
        end else if (wb_stall) begin
            retire_pulse  <= 1'b0;
        end else begin
            wb_valid      <= mem_valid;
            wb_regwrite   <= mem_valid & wen_s;
            wb_rd         <= mem_rd;
            wb_rs1        <= mem_rs1;
            wb_rs2        <= mem_rs2;
            wb_write_data <= sel_data_s;
            wb_instr      <= mem_instr;
            retire_pulse  <= mem_valid;
            if (mem_valid) begin
                retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retire_count <= retire_count;
            end
            if (mem_valid & wen_s) begin
                last_wb_data <= sel_data_s;
            end else begin
                last_wb_data <= last_wb_data;
            end
        end
    end

endmodule : wb_stage_pipe

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised writeback stage that registers MEM-stage results into the WB stage and drives the register-file write port. Supersedes the fixed 32-bit writeback register. Adds:
- valid tracking, stall and flush;
- ALU/load result selection with load sign/zero extension;
- x0 write suppression;
- a retired-instruction counter.

It sits between the MEM stage and the RegFile. Its outputs also feed the hazard unit and the debug view.

## Interface
Parameters:
- XLEN, 32, data and instruction width (32 or 64)
- RA_W, 5, register index width
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  MEM slot holds a real instruction
- mem_regwrite  in  1  instruction writes rd
- mem_memtoreg  in  1  1 = select load data, 0 = select ALU result
- mem_funct3  in  3  load size/sign code
- mem_rd  in  RA_W  destination index
- mem_rs1, mem_rs2  in  RA_W  source indices, passed through
- mem_alu_result  in  XLEN  ALU result
- mem_load_data  in  XLEN  load data, already right-aligned to bit 0 by the MEM stage
- mem_instr  in  32  instruction word
- wb_stall  in  1  hold the WB register
- wb_flush  in  1  replace the incoming instruction with a bubble
- wb_valid  out  1  WB slot holds a real instruction
- wb_regwrite  out  1  RegFile write enable
- wb_rd  out  RA_W  RegFile write index
- wb_write_data  out  XLEN  RegFile write data
- wb_rs1, wb_rs2  out  RA_W  registered source indices
- wb_instr  out  32  registered instruction word
- last_wb_data  out  XLEN  value of the most recent committed non-x0 write
- retire_count  out  CNT_W  number of instructions retired
- retire_pulse  out  1  one-cycle pulse when an instruction is captured

## Operation
- Capture event: `cap = mem_valid & ~wb_stall & ~wb_flush`. Effective write: `wen = mem_regwrite & (mem_rd != 0)`.
- Each cycle, priority flush > stall > normal:
  - **Flush:** wb_valid=0, wb_regwrite=0, wb_rd=0, wb_rs1=0, wb_rs2=0, wb_write_data=0, wb_instr=NOP (0x00000013). The counter and last_wb_data are unchanged.
  - **Stall (no flush):** all WB registers, the counter and last_wb_data hold their values. retire_pulse=0.
  - **Normal:** wb_valid=mem_valid and wb_regwrite=mem_valid&wen. rd, rs1, rs2 and instr are copied from MEM. wb_write_data = memtoreg ? ext(load_data) : alu_result.
- Load extension, `ext(d)` by mem_funct3:
  - 000: sign-extend d[7:0]
  - 001: sign-extend d[15:0]
  - 010: sign-extend d[31:0] (identity when XLEN=32)
  - 100: zero-extend d[7:0]
  - 101: zero-extend d[15:0]
  - 110: zero-extend d[31:0]
  - 011 and 111: pass d unchanged
- mem_valid=0 in a normal cycle loads a bubble. wb_regwrite is forced to 0; data fields still load their MEM values.
- Write to x0 (mem_rd=0 with mem_regwrite=1): wb_valid=1, wb_regwrite=0. The instruction still counts as retired, and last_wb_data does not update.
- last_wb_data is updated with the new wb_write_data when `cap & wen`.
- retire_count increments by 1 on `cap` and wraps modulo 2^CNT_W without saturating. retire_pulse is registered to `cap`.

## Timing
- Latency is 1 cycle from MEM inputs to WB outputs.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values:
  - wb_valid, wb_regwrite, retire_pulse = 0
  - wb_rd, wb_rs1, wb_rs2 = 0
  - wb_write_data, last_wb_data, retire_count = 0
  - wb_instr = NOP
- Reset asserted mid-operation clears all outputs immediately, without waiting for an edge. The first capture happens on the first rising edge after reset deasserts.
- Simultaneous wb_stall and wb_flush: the flush wins.
- A stall lasting N cycles holds the outputs constant for those N cycles. The RegFile sees the held wb_regwrite, and a repeated write of the same value is harmless.
- Counter wrap: the capture at count 2^CNT_W−1 produces a count of 0 and retire_pulse=1.

## Structure
- Shared package `wb_pkg`:
  - funct3 load codes: LB, LH, LW, LBU, LHU, LWU
  - NOP_INSTR constant = 0x00000013
- One combinational sub-module, `wb_load_ext` (parameter XLEN; inputs funct3 and data; output extended data). The rest of the block is a single always block with asynchronous reset.

## Test plan
- **Reset:** assert reset mid-stream → all outputs reset to the values above within the same cycle. wb_instr=0x00000013.
- **ALU write:** MEM presents valid, regwrite, rd=5, alu_result=0x1234, memtoreg=0 → next cycle wb_regwrite=1, wb_rd=5, wb_write_data=0x1234, last_wb_data=0x1234, retire_count=1.
- **Loads with load_data=0x0000_80F0:**
  - funct3=000 → 0xFFFF_FFF0
  - funct3=100 → 0x0000_00F0
  - funct3=001 → 0xFFFF_80F0
  - funct3=101 → 0x0000_80F0
- **x0 write:** rd=0, regwrite=1, alu_result=0xDEAD → wb_valid=1, wb_regwrite=0. last_wb_data is unchanged and retire_count increments.
- **Stall then flush:** stall for 3 cycles → outputs and count held. Then flush together with stall → bubble loaded (wb_valid=0, wb_instr=NOP), count unchanged.
- **Wrap:** CNT_W=4, 17 valid captures → retire_count=1, with retire_pulse high on every capture.
